dec139_rr_arbiter: RTL

Four-requester round-robin arbiter that shares one half of a 74x139-style 2-to-4 decoder among four bus masters. It registers the decoder's enable G (active-low) and selects B/A, and drives the decoded active-low one-cold grant vector Y. A hold limit stops any single requester from monopolising the resource. It sits between the requester logic and the decoded chip-select fabric.

---
 rtl/dec139_rr_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dec139_rr_arbiter.sv
// Four-requester round-robin arbiter driving one half of a 74x139-style 2-to-4 decoder.
// Registered G/B/A select the owner; Y is the decoded active-low one-cold grant.
module dec139_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       REQ,
  output logic             G,
  output logic             B,
  output logic             A,
  output logic [3:0]       Y,
  output logic             BUSY,
  output logic [CNT_W-1:0] HOLD
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [1:0]       sel_reg, sel_next;
  logic             g_reg, g_next;
  logic             busy_reg, busy_next;
  logic [CNT_W-1:0] hold_reg, hold_next;

  logic [3:0]       owner_mask;
  logic [3:0]       cand_req;
  logic [1:0]       cand_idx [4];
  logic [3:0]       cand_hit;
  logic [1:0]       win_idx;
  logic             win_found;
  logic             own_req;

  // Decode and round-robin search slots: slot gi looks at index ptr+1+gi.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      assign owner_mask[gi] = (sel_reg == 2'(gi));
      assign Y[gi]          = ~(~g_reg & owner_mask[gi]);
      assign cand_idx[gi]   = ptr_reg + 2'(gi + 1);
      assign cand_hit[gi]   = cand_req[cand_idx[gi]];
    end
  endgenerate

  // While granted, the current owner is excluded from the competitor search.
  assign cand_req = (state_reg == GRANT) ? (REQ & ~owner_mask) : REQ;
  assign own_req  = |(REQ & owner_mask);

  always_comb begin
    win_idx   = ptr_reg;
    win_found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (cand_hit[k]) begin
        win_idx   = cand_idx[k];
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    g_next     = g_reg;
    busy_next  = busy_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = GRANT;
          sel_next   = win_idx;
          ptr_next   = win_idx;
          g_next     = 1'b0;
          busy_next  = 1'b1;
          hold_next  = HOLD_ONE;
        end
      end
      GRANT: begin
        if (own_req && ((hold_reg < HOLD_MAX) || !win_found)) begin
          if (hold_reg < HOLD_MAX) begin
            hold_next = hold_reg + HOLD_ONE;
          end
        end else if (win_found) begin
          // Release-with-waiter or preemption: hand over on this edge, no idle gap.
          sel_next  = win_idx;
          ptr_next  = win_idx;
          hold_next = HOLD_ONE;
        end else begin
          state_next = IDLE;
          g_next     = 1'b1;
          busy_next  = 1'b0;
          hold_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        g_next     = 1'b1;
        busy_next  = 1'b0;
        hold_next  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd3;
      sel_reg   <= 2'd0;
      g_reg     <= 1'b1;
      busy_reg  <= 1'b0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      g_reg     <= g_next;
      busy_reg  <= busy_next;
      hold_reg  <= hold_next;
    end
  end

  assign G    = g_reg;
  assign B    = sel_reg[1];
  assign A    = sel_reg[0];
  assign BUSY = busy_reg;
  assign HOLD = hold_reg;

endmodule
